// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-port RAM between the CPU control path and the program loader.
// CPU has priority, a starvation counter guarantees the loader a slot, and a lock gives the loader exclusive bursts.
module ram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cpu_req,
   input  logic                  i_cpu_we,
   input  logic                  i_cpu_jmp,
   input  logic [DATA_WIDTH-1:0] i_cpu_addr,
   input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
   output logic                  o_cpu_gnt,
   output logic                  o_cpu_rvalid,
   output logic [DATA_WIDTH-1:0] o_cpu_rdata,
   input  logic                  i_ld_req,
   input  logic                  i_ld_we,
   input  logic                  i_ld_lock,
   input  logic [DATA_WIDTH-1:0] i_ld_addr,
   input  logic [DATA_WIDTH-1:0] i_ld_wdata,
   output logic                  o_ld_gnt,
   output logic                  o_ld_rvalid,
   output logic [DATA_WIDTH-1:0] o_ld_rdata,
   output logic                  o_ram_we,
   output logic                  o_ram_jmp,
   output logic [DATA_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   state_t                state_q, state_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic                  cpu_gnt, ld_gnt;
   logic                  cpu_rvalid_q, cpu_rvalid_d;
   logic                  ld_rvalid_q, ld_rvalid_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

   // Grants are gated by reset so nothing reaches the RAM while reset is asserted.
   always_comb begin
      cpu_gnt    = 1'b0;
      ld_gnt     = 1'b0;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      if (i_rst_n) begin
         case (state_q)
            ARB: begin
               if (i_ld_req && (!i_cpu_req || wait_cnt_q == WAIT_LIMIT)) begin
                  ld_gnt = 1'b1;
               end else begin
                  cpu_gnt = i_cpu_req;
               end
               if (ld_gnt && i_ld_lock) begin
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               ld_gnt = i_ld_req;
               if (!i_ld_req || !i_ld_lock) begin
                  state_d = ARB;
               end
            end
            default: state_d = ARB;
         endcase
         if (!i_ld_req || ld_gnt) begin
            wait_cnt_d = 4'd0;
         end else if (state_q == ARB && wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      o_ram_we    = 1'b0;
      o_ram_jmp   = 1'b0;
      o_ram_addr  = '0;
      o_ram_wdata = '0;
      if (cpu_gnt) begin
         o_ram_we    = i_cpu_we;
         o_ram_jmp   = i_cpu_jmp & ~i_cpu_we;
         o_ram_addr  = i_cpu_addr;
         o_ram_wdata = i_cpu_wdata;
      end else if (ld_gnt) begin
         o_ram_we    = i_ld_we;
         o_ram_addr  = i_ld_addr;
         o_ram_wdata = i_ld_wdata;
      end
   end

   // Read data is captured at the grant edge and held until that requester's next read.
   always_comb begin
      cpu_rvalid_d = cpu_gnt & ~i_cpu_we;
      ld_rvalid_d  = ld_gnt & ~i_ld_we;
      cpu_rdata_d  = cpu_rvalid_d ? i_ram_rdata : cpu_rdata_q;
      ld_rdata_d   = ld_rvalid_d ? i_ram_rdata : ld_rdata_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ARB;
         wait_cnt_q   <= 4'd0;
         cpu_rvalid_q <= 1'b0;
         ld_rvalid_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         ld_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         ld_rvalid_q  <= ld_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ld_rdata_q   <= ld_rdata_d;
      end
   end

   assign o_cpu_gnt    = cpu_gnt;
   assign o_ld_gnt     = ld_gnt;
   assign o_cpu_rvalid = cpu_rvalid_q;
   assign o_ld_rvalid  = ld_rvalid_q;
   assign o_cpu_rdata  = cpu_rdata_q;
   assign o_ld_rdata   = ld_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 16-word RAM model; jump reads return the low nibble.
module tb_ram_arbiter;
   localparam int DW = 8;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req, cpu_we, cpu_jmp;
   logic [DW-1:0] cpu_addr, cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          ld_req, ld_we, ld_lock;
   logic [DW-1:0] ld_addr, ld_wdata;
   logic          ld_gnt, ld_rvalid;
   logic [DW-1:0] ld_rdata;
   logic          ram_we, ram_jmp;
   logic [DW-1:0] ram_addr, ram_wdata, ram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_jmp(cpu_jmp),
      .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
      .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_lock(ld_lock),
      .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
      .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid), .o_ld_rdata(ld_rdata),
      .o_ram_we(ram_we), .o_ram_jmp(ram_jmp), .o_ram_addr(ram_addr),
      .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
   );

   logic [DW-1:0] mem [16];
   logic [DW-1:0] mem_word;
   assign mem_word  = mem[ram_addr[3:0]];
   assign ram_rdata = ram_jmp ? {4'h0, mem_word[3:0]} : mem_word;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) mem[k] <= '0;
      end else if (ram_we) begin
         mem[ram_addr[3:0]] <= ram_wdata;
      end
   end

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_jmp = 0; cpu_addr = 0; cpu_wdata = 0;
      ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = 0; ld_wdata = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({cpu_rvalid, ld_rvalid, cpu_gnt, ld_gnt} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got=%b exp=0000", {cpu_rvalid, ld_rvalid, cpu_gnt, ld_gnt});
      end
      checks++;
      if (cpu_rdata !== 8'h00 || ld_rdata !== 8'h00) begin
         errors++; $display("FAIL reset_rdata got=%h/%h exp=00/00", cpu_rdata, ld_rdata);
      end
      @(negedge clk) rst_n = 1;
      $display("reset done");
   endtask

   task automatic test_cpu_only();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 3; cpu_wdata = 8'hA5;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'd3 || ram_wdata !== 8'hA5) begin
         errors++; $display("FAIL cpu_write gnt=%b we=%b addr=%h wd=%h exp 1 1 03 a5", cpu_gnt, ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk);
      cpu_we = 0;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || ram_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
         errors++; $display("FAIL cpu_read_gnt gnt=%b we=%b rvalid=%b exp 1 0 0", cpu_gnt, ram_we, cpu_rvalid);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5) begin
         errors++; $display("FAIL cpu_read_data rvalid=%b rdata=%h exp 1 a5", cpu_rvalid, cpu_rdata);
      end
      checks++;
      if (cpu_gnt !== 1'b0 || ram_addr !== 8'd0 || ram_we !== 1'b0) begin
         errors++; $display("FAIL idle_drive gnt=%b addr=%h we=%b exp 0 00 0", cpu_gnt, ram_addr, ram_we);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA5) begin
         errors++; $display("FAIL cpu_rdata_hold rvalid=%b rdata=%h exp 0 a5", cpu_rvalid, cpu_rdata);
      end
      $display("cpu write/read addr 3 done");
   endtask

   task automatic test_jump();
      @(negedge clk);
      ld_req = 1; ld_we = 1; ld_addr = 5; ld_wdata = 8'h9C;
      #1;
      checks++;
      if (ld_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_we !== 1'b1 || ram_jmp !== 1'b0) begin
         errors++; $display("FAIL ld_write ld_gnt=%b cpu_gnt=%b we=%b jmp=%b exp 1 0 1 0", ld_gnt, cpu_gnt, ram_we, ram_jmp);
      end
      @(negedge clk);
      idle();
      cpu_req = 1; cpu_jmp = 1; cpu_addr = 5;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || ram_jmp !== 1'b1 || ld_rvalid !== 1'b0) begin
         errors++; $display("FAIL jmp_read gnt=%b jmp=%b ld_rvalid=%b exp 1 1 0", cpu_gnt, ram_jmp, ld_rvalid);
      end
      @(negedge clk);
      cpu_we = 1; cpu_addr = 6; cpu_wdata = 8'h77;
      #1;
      checks++;
      if (ram_jmp !== 1'b0 || ram_we !== 1'b1) begin
         errors++; $display("FAIL jmp_on_write jmp=%b we=%b exp 0 1", ram_jmp, ram_we);
      end
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h0C) begin
         errors++; $display("FAIL jmp_data rvalid=%b rdata=%h exp 1 0c", cpu_rvalid, cpu_rdata);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0) begin
         errors++; $display("FAIL write_no_rvalid rvalid=%b exp 0", cpu_rvalid);
      end
      $display("jump read done");
   endtask

   task automatic test_starvation();
      logic exp_ld, prev_ld;
      prev_ld = 1'b0;
      @(negedge clk);
      cpu_req = 1; cpu_addr = 3;
      ld_req = 1; ld_addr = 5;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp_ld = (i % 5 == 4);
         checks++;
         if (ld_gnt !== exp_ld || cpu_gnt !== !exp_ld) begin
            errors++; $display("FAIL starve_gnt cycle=%0d cpu=%b ld=%b exp cpu=%b ld=%b", i, cpu_gnt, ld_gnt, !exp_ld, exp_ld);
         end
         if (i > 0) begin
            checks++;
            if (ld_rvalid !== prev_ld || cpu_rvalid !== !prev_ld) begin
               errors++; $display("FAIL starve_rvalid cycle=%0d cpu=%b ld=%b exp cpu=%b ld=%b", i, cpu_rvalid, ld_rvalid, !prev_ld, prev_ld);
            end
            checks++;
            if (prev_ld && ld_rdata !== 8'h9C) begin
               errors++; $display("FAIL starve_ld_data cycle=%0d got=%h exp=9c", i, ld_rdata);
            end else if (!prev_ld && cpu_rdata !== 8'hA5) begin
               errors++; $display("FAIL starve_cpu_data cycle=%0d got=%h exp=a5", i, cpu_rdata);
            end
         end
         $display("starve cycle %0d cpu_gnt=%b ld_gnt=%b", i, cpu_gnt, ld_gnt);
         prev_ld = exp_ld;
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_lock_burst();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ld_req = 1; ld_we = 1; ld_lock = (i != 15);
         ld_addr = 8'(i); ld_wdata = 8'(8'h10 + i);
         cpu_req = (i > 0); cpu_we = 0; cpu_addr = 15;
         #1;
         checks++;
         if (ld_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            errors++; $display("FAIL lock_burst i=%0d ld=%b cpu=%b exp ld=1 cpu=0", i, ld_gnt, cpu_gnt);
         end
         $display("burst write addr %0d", i);
      end
      @(negedge clk);
      ld_req = 0; ld_we = 0; ld_lock = 0;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++; $display("FAIL unlock_cpu_gnt got=%b exp=1", cpu_gnt);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h1F) begin
         errors++; $display("FAIL burst_readback rvalid=%b rdata=%h exp 1 1f", cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_lock_abandon();
      @(negedge clk);
      ld_req = 1; ld_we = 1; ld_lock = 1; ld_addr = 0; ld_wdata = 8'h10;
      #1;
      checks++;
      if (ld_gnt !== 1'b1) begin
         errors++; $display("FAIL abandon_lock_gnt got=%b exp=1", ld_gnt);
      end
      @(negedge clk);
      idle();
      cpu_req = 1; cpu_addr = 3;
      #1;
      checks++;
      if (cpu_gnt !== 1'b0) begin
         errors++; $display("FAIL abandon_still_locked cpu_gnt=%b exp=0", cpu_gnt);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++; $display("FAIL abandon_cpu_gnt got=%b exp=1", cpu_gnt);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h13) begin
         errors++; $display("FAIL abandon_read rvalid=%b rdata=%h exp 1 13", cpu_rvalid, cpu_rdata);
      end
      $display("lock abandon done");
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      cpu_req = 1; cpu_addr = 3;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++; $display("FAIL midrst_gnt got=%b exp=1", cpu_gnt);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1) begin
         errors++; $display("FAIL midrst_rvalid_before got=%b exp=1", cpu_rvalid);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, ram_we, ram_jmp} !== 6'b0 ||
          ram_addr !== 8'h00 || ram_wdata !== 8'h00 || cpu_rdata !== 8'h00) begin
         errors++; $display("FAIL midrst_outputs flags=%b addr=%h wd=%h rdata=%h exp 000000 00 00 00",
                            {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, ram_we, ram_jmp}, ram_addr, ram_wdata, cpu_rdata);
      end
      idle();
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (cpu_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin
            errors++; $display("FAIL midrst_stale cycle=%0d cpu=%b ld=%b exp 0 0", i, cpu_rvalid, ld_rvalid);
         end
      end
      $display("reset mid-read done");
   endtask

   initial begin
      idle();
      test_reset();
      test_cpu_only();
      test_jump();
      test_starvation();
      test_lock_burst();
      test_lock_abandon();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 16-word program/data RAM between two requesters: the CPU control path (fetch, operand read, store, jump-read) and the program loader, which fills RAM before and during run.
- CPU has priority. A starvation counter guarantees the loader a slot, and a lock mode gives the loader exclusive ownership for burst program loads.
- Sits between the requesters and the RAM's write-enable, jump, address, write-data and read-data pins. Read data returns registered, one cycle after grant.

Parameters:
- DATA_WIDTH, 8, width of address, data and bus words.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader wins over the CPU (range 1..15).

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_cpu_req  input  1  CPU access request, held until granted
- i_cpu_we  input  1  CPU write (1) / read (0)
- i_cpu_jmp  input  1  CPU jump-format read (ignored on writes)
- i_cpu_addr  input  DATA_WIDTH  CPU address
- i_cpu_wdata  input  DATA_WIDTH  CPU write data
- o_cpu_gnt  output  1  CPU access performed at the end of this cycle
- o_cpu_rvalid  output  1  CPU read data valid (1-cycle pulse)
- o_cpu_rdata  output  DATA_WIDTH  CPU read data, registered
- i_ld_req  input  1  loader access request
- i_ld_we  input  1  loader write (1) / read (0)
- i_ld_lock  input  1  loader requests/keeps exclusive ownership
- i_ld_addr  input  DATA_WIDTH  loader address
- i_ld_wdata  input  DATA_WIDTH  loader write data
- o_ld_gnt  output  1  loader access performed at the end of this cycle
- o_ld_rvalid  output  1  loader read data valid (1-cycle pulse)
- o_ld_rdata  output  DATA_WIDTH  loader read data, registered
- o_ram_we  output  1  to RAM write enable
- o_ram_jmp  output  1  to RAM jump-read select
- o_ram_addr  output  DATA_WIDTH  to RAM address (RAM decodes bits 3:0)
- o_ram_wdata  output  DATA_WIDTH  to RAM write data
- i_ram_rdata  input  DATA_WIDTH  from RAM combinational read data

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: rvalids 0, rdatas 0, wait_cnt 0, state ARB. Grants are combinational and therefore 0 whenever no request is present.
- Reset mid-operation: any read whose rvalid is due next cycle is dropped, with no pulse after reset release.
- FSM has two states:
  - ARB: CPU wins if i_cpu_req, unless i_ld_req and wait_cnt==MAX_WAIT, in which case the loader wins. A lone requester always wins.
  - LOCKED: only the loader can be granted. o_cpu_gnt=0 regardless of i_cpu_req.
- FSM transitions:
  - ARB->LOCKED on a loader grant with i_ld_lock=1.
  - LOCKED->ARB on a loader grant with i_ld_lock=0, or on any cycle with i_ld_req=0.
- Grant rules: at most one grant per cycle, never both. Grants are combinational from requests and state; the access commits at the closing rising edge.
- RAM drive when a requester is granted:
  - o_ram_addr/o_ram_wdata/o_ram_we come from the granted requester.
  - o_ram_jmp = o_cpu_gnt & i_cpu_jmp & ~i_cpu_we.
  - The loader never drives jmp.
- RAM drive with no grant: we=0, jmp=0, addr=0, wdata=0.
- wait_cnt (4 bits):
  - +1 on cycles with i_ld_req & ~o_ld_gnt, saturating at MAX_WAIT.
  - Cleared on o_ld_gnt or when i_ld_req=0.
  - Not incremented in LOCKED (the loader is always granted there).
- Read return: a granted read captures i_ram_rdata into the requester's rdata register at the grant edge. The matching rvalid is high for exactly the following cycle.
- rdata holds its value until the next read by the same requester. Writes never raise rvalid.
- Back-to-back: a requester may be granted every cycle. Consecutive reads give consecutive rvalid pulses with matching data.
- Write then read of the same address in consecutive cycles returns the new data.
- Requesters must hold req/we/addr/wdata stable until granted. A request dropped before grant is legal and simply not performed.
- CPU starvation in LOCKED is intentional. The loader is responsible for releasing the lock.

Test Plan:
- Reset/idle: assert i_rst_n=0 mid-read -> all rvalid/gnt 0, o_ram_* 0; after release, no stale rvalid.
- CPU only: write 0xA5 to addr 3, then read addr 3 -> o_cpu_gnt both cycles; o_cpu_rvalid one cycle after the read grant with o_cpu_rdata=0xA5.
- Jump read: memory[5]=0x9C, CPU read with jmp=1 -> o_ram_jmp=1 during grant; o_cpu_rdata=0x0C next cycle. The same access with we=1 -> o_ram_jmp=0.
- Starvation (MAX_WAIT=4): both request continuously -> CPU granted 4 cycles, loader granted the 5th, then CPU 4 more cycles; pattern repeats and never yields two grants in one cycle.
- Lock burst: loader writes 0x10..0x1F to addrs 0..15 with lock=1 while the CPU requests -> o_cpu_gnt=0 for all 16 cycles. Final write with lock=0 -> CPU granted the next cycle; CPU reads addr 15 and gets 0x1F.
- Lock abandon: in LOCKED, loader drops i_ld_req for one cycle -> state ARB the next cycle, pending CPU request granted.
